// File: rtl/gpio_input_capture_if.sv
// Pin-side signal bundle of the GPIO input-capture block.
// The slave modport is the capture block; the master modport drives the pad and config side.
interface gpio_input_capture_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] ioPin;
  logic             outEn;
  logic             cfgWe;
  logic [WIDTH-1:0] cfgRiseEn;
  logic [WIDTH-1:0] cfgFallEn;
  logic [WIDTH-1:0] irqClr;
  logic [WIDTH-1:0] iData;
  logic [WIDTH-1:0] irqPending;
  logic             irq;

  modport master (
    output ioPin, outEn, cfgWe, cfgRiseEn, cfgFallEn, irqClr,
    input  iData, irqPending, irq
  );

  modport slave (
    input  ioPin, outEn, cfgWe, cfgRiseEn, cfgFallEn, irqClr,
    output iData, irqPending, irq
  );
endinterface

// File: rtl/gpio_input_capture.sv
// Per-pin GPIO input path: synchronizer, debounce, edge detect and sticky
// interrupt flags, with flagging masked while the core drives the pads.
module gpio_input_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                 clk,
  input logic                 RSTn,
  gpio_input_capture_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] syncChain [SYNC_STAGES];
  logic [WIDTH-1:0] syncBit;
  logic [WIDTH-1:0] stable;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] setBit;
  logic [WIDTH-1:0] riseEn;
  logic [WIDTH-1:0] fallEn;
  logic [WIDTH-1:0] pending;

  // Synchronizer stage boundary: only syncChain[0] ever samples the pad.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int s = 0; s < SYNC_STAGES; s++) syncChain[s] <= '0;
    end else begin
      syncChain[0] <= bus.ioPin;
      for (int s = 1; s < SYNC_STAGES; s++) syncChain[s] <= syncChain[s-1];
    end
  end

  assign syncBit  = syncChain[SYNC_STAGES-1];
  assign mismatch = syncBit ^ stable;

  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) accept[i] = mismatch[i] && (cnt[i] == CNT_LAST);
  end

  // An accepted bit always flips stable, so the new level is syncBit.
  assign rise   = accept & syncBit;
  assign fall   = accept & ~syncBit;
  assign setBit = {WIDTH{~bus.outEn}} & ((rise & riseEn) | (fall & fallEn));

  // Debounce stage boundary: any return to equality restarts the count.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable <= stable ^ accept;
      for (int i = 0; i < WIDTH; i++) begin
        if (!mismatch[i] || accept[i]) cnt[i] <= '0;
        else                           cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  // Flag stage boundary: a set in the same cycle as its clear wins.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      riseEn  <= '0;
      fallEn  <= '0;
      pending <= '0;
    end else begin
      if (bus.cfgWe) begin
        riseEn <= bus.cfgRiseEn;
        fallEn <= bus.cfgFallEn;
      end
      pending <= setBit | (pending & ~bus.irqClr);
    end
  end

  assign bus.iData      = stable;
  assign bus.irqPending = pending;
  assign bus.irq        = |pending;
endmodule

// File: tb/tb_gpio_input_capture.sv
// Directed bench for gpio_input_capture (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
// stimulus queues edge-tagged expectations, a negedge monitor consumes them.
module tb_gpio_input_capture;
  logic clk;
  logic RSTn;
  int   edges = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic [7:0] p;
    string      nm;
  } exp_t;

  exp_t q[$];

  gpio_input_capture_if #(.WIDTH(8)) bus ();

  gpio_input_capture #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk (clk),
    .RSTn(RSTn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Expected outputs after the edge that is dly edges from now.
  task automatic expect_at(input int dly, input logic [7:0] d, input logic [7:0] p, input string nm);
    exp_t e;
    e.cyc = edges + dly;
    e.d   = d;
    e.p   = p;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc == edges) begin
        total += 3;
        if (bus.iData !== q[i].d) begin
          bad++;
          $display("FAIL %s iData @edge %0d: got %h want %h", q[i].nm, edges, bus.iData, q[i].d);
        end
        if (bus.irqPending !== q[i].p) begin
          bad++;
          $display("FAIL %s irqPending @edge %0d: got %h want %h", q[i].nm, edges, bus.irqPending, q[i].p);
        end
        if (bus.irq !== (q[i].p != 8'h00)) begin
          bad++;
          $display("FAIL %s irq @edge %0d: got %b want %b", q[i].nm, edges, bus.irq, (q[i].p != 8'h00));
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    RSTn          = 1'b0;
    bus.ioPin     = 8'h00;
    bus.outEn     = 1'b0;
    bus.cfgWe     = 1'b0;
    bus.cfgRiseEn = 8'h00;
    bus.cfgFallEn = 8'h00;
    bus.irqClr    = 8'h00;
    tick(2);
    expect_at(0, 8'h00, 8'h00, "reset");
    tick(1);
    RSTn = 1'b1;
    tick(2);

    // Latency: pin 0 rises, enables still zero.
    bus.ioPin = 8'h01;
    expect_at(5, 8'h00, 8'h00, "lat_before");
    expect_at(6, 8'h01, 8'h00, "lat_exact");
    tick(8);
    bus.ioPin = 8'h00;
    expect_at(6, 8'h00, 8'h00, "fall_noflag");
    tick(8);

    // Glitch of 3 cycles rejected, 4 cycles accepted and flagged.
    bus.cfgWe     = 1'b1;
    bus.cfgRiseEn = 8'h01;
    bus.cfgFallEn = 8'h00;
    tick(1);
    bus.cfgWe = 1'b0;
    bus.ioPin = 8'h01;
    for (int k = 1; k <= 9; k++) expect_at(k, 8'h00, 8'h00, "glitch3");
    tick(3);
    bus.ioPin = 8'h00;
    tick(8);
    bus.ioPin = 8'h01;
    expect_at(5, 8'h00, 8'h00, "pulse4_pre");
    expect_at(6, 8'h01, 8'h01, "pulse4_rise");
    expect_at(9, 8'h01, 8'h01, "pulse4_hold");
    expect_at(10, 8'h00, 8'h01, "pulse4_fall");
    tick(4);
    bus.ioPin = 8'h00;
    tick(10);

    // Falling edge on pin 7 masked by outEn, then flagged without it.
    bus.cfgWe     = 1'b1;
    bus.cfgRiseEn = 8'h01;
    bus.cfgFallEn = 8'h80;
    tick(1);
    bus.cfgWe = 1'b0;
    bus.ioPin = 8'h80;
    expect_at(6, 8'h80, 8'h01, "p7_rise");
    tick(8);
    bus.outEn = 1'b1;
    bus.ioPin = 8'h00;
    expect_at(6, 8'h00, 8'h01, "p7_fall_outEn");
    tick(8);
    bus.outEn = 1'b0;
    bus.ioPin = 8'h80;
    tick(8);
    bus.ioPin = 8'h00;
    expect_at(5, 8'h80, 8'h01, "p7_fall_pre");
    expect_at(6, 8'h00, 8'h81, "p7_fall_flag");
    tick(8);

    // Clear pin 7, then set-vs-clear collision on pin 0.
    bus.irqClr = 8'h80;
    expect_at(1, 8'h00, 8'h01, "clr7");
    tick(1);
    bus.irqClr = 8'h00;
    bus.ioPin  = 8'h01;
    expect_at(5, 8'h00, 8'h01, "collide_pre");
    expect_at(6, 8'h01, 8'h01, "set_wins");
    expect_at(7, 8'h01, 8'h00, "clr_alone");
    tick(5);
    bus.irqClr = 8'h01;
    tick(2);
    bus.irqClr = 8'h00;
    bus.ioPin  = 8'h00;
    expect_at(6, 8'h00, 8'h00, "p0_fall");
    tick(8);

    // Pin 3 toggling every 2 cycles never debounces.
    for (int k = 0; k < 20; k++) begin
      bus.ioPin[3] = ~bus.ioPin[3];
      expect_at(1, 8'h00, 8'h00, "toggle");
      tick(2);
    end
    expect_at(4, 8'h00, 8'h00, "toggle_end");
    tick(6);

    // Async reset mid-count with a pending flag.
    bus.ioPin = 8'h01;
    expect_at(6, 8'h01, 8'h01, "pre_reset_flag");
    tick(8);
    bus.ioPin = 8'h09;
    tick(4);
    RSTn = 1'b0;
    expect_at(0, 8'h00, 8'h00, "async_reset");
    tick(2);
    expect_at(0, 8'h00, 8'h00, "reset_held");
    RSTn = 1'b1;
    expect_at(5, 8'h00, 8'h00, "post_reset_pre");
    expect_at(6, 8'h09, 8'h00, "post_reset_rise");
    tick(8);

    tick(2);
    foreach (q[i]) begin
      total++;
      bad++;
      $display("FAIL %s never checked: due edge %0d, now %0d", q[i].nm, q[i].cyc, edges);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_input_capture.md
Name: gpio_input_capture

Overview:
- Input-direction companion to the GPIO pad block, per pin.
- Takes the raw pad level (ioPin as seen by the core), synchronizes it into clk, debounces it and exposes a stable iData level.
- Detects rising/falling edges on the debounced level and raises per-pin sticky interrupt flags plus one combined irq line for the processor's interrupt controller.
- Edge flagging is suppressed while the pad is driven by the output path (outEn=1), so the core's own writes never raise interrupts.

Parameters:
- WIDTH, 8: number of pins handled.
- SYNC_STAGES, 2: flops in the synchronizer chain (min 2).
- DEBOUNCE_CYCLES, 16: consecutive cycles a new level must persist before acceptance (min 1).
- Counter width is $clog2(DEBOUNCE_CYCLES)+1; it is derived, not a parameter.

Ports:
- clk  input  1  system clock
- RSTn  input  1  asynchronous, active-low reset
- ioPin  input  WIDTH  raw pad level, asynchronous to clk
- outEn  input  1  pad output enable; 1 = pins driven by core, edge flagging disabled
- cfgWe  input  1  one-cycle strobe; loads cfgRiseEn/cfgFallEn
- cfgRiseEn  input  WIDTH  per-pin rising-edge interrupt enable (write data)
- cfgFallEn  input  WIDTH  per-pin falling-edge interrupt enable (write data)
- irqClr  input  WIDTH  write-1-to-clear pulse for pending flags
- iData  output  WIDTH  debounced pin level
- irqPending  output  WIDTH  sticky per-pin edge flags
- irq  output  1  OR of irqPending

Behaviour:
- Reset (RSTn low, async): all synchronizer flops, stable levels, debounce counters, rise/fall enables and pending flags go to 0. Outputs iData=0, irqPending=0, irq=0.
- Reset mid-debounce: the count is discarded and restarts after release.
- Synchronizer: per bit, SYNC_STAGES-deep chain. Its output is syncBit; nothing else samples ioPin.
- Debounce, per bit, with counter cnt and register stable (= iData):
  - syncBit == stable: cnt <= 0.
  - syncBit != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - syncBit != stable and cnt == DEBOUNCE_CYCLES-1: stable <= syncBit, cnt <= 0.
  - A mismatch must therefore be present on DEBOUNCE_CYCLES consecutive edges.
  - Any return to equality resets cnt; the count does not pause.
- Latency: a clean pin change held steady appears on iData exactly SYNC_STAGES+DEBOUNCE_CYCLES rising clk edges after the first edge that samples the new level.
- Glitch rejection: pulses shorter than DEBOUNCE_CYCLES cycles (after sync) never reach iData.
- Edge events, evaluated on the cycle stable updates:
  - rise = stable 0->1; fall = stable 1->0.
  - setBit = ~outEn & ((rise & riseEn) | (fall & fallEn)).
  - outEn is sampled in the same cycle as the stable update.
- Pending flags: irqPending[i] <= setBit[i] | (irqPending[i] & ~irqClr[i]). Set and clear in the same cycle: set wins, flag stays 1.
- Config: on cfgWe, riseEn <= cfgRiseEn and fallEn <= cfgFallEn.
  - Changing an enable never sets or clears a pending flag.
  - An edge in the same cycle as cfgWe uses the old enables.
- irq: combinational OR of the irqPending flops; no added latency.
- iData keeps tracking the pad while outEn=1; only flagging is masked.
- No handshake; all strobes are single-cycle and level-safe (holding a strobe high repeats an idempotent action).

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2 unless noted):
1. Reset, ioPin=8'h00, then ioPin[0]=1 held -> iData=8'h01 exactly 6 edges after first sampling edge; irqPending=0 since enables are 0.
2. cfgWe with cfgRiseEn=8'h01; ioPin[0] high pulse of 3 cycles -> iData unchanged, irq=0. Pulse of 4 cycles -> iData[0]=1 then back to 0 after release; irqPending=8'h01, irq=1.
3. cfgFallEn=8'h80, ioPin[7] 1->0 while outEn=1 -> iData[7] follows, irqPending[7] stays 0. Repeat with outEn=0 -> irqPending[7]=1.
4. irqPending=8'h01; assert irqClr=8'h01 in the same cycle a new rising event on pin 0 sets the flag -> irqPending[0] stays 1. Next cycle irqClr alone -> 0, irq=0.
5. ioPin[3] toggling every 2 cycles for 40 cycles -> iData[3] never changes, cnt never reaches 3.
6. Assert RSTn low during a debounce count (cnt=2) with pending flags set -> all outputs 0 immediately (async). After release with pin held high -> iData rises after 6 edges; no flag because the enables were reset.
